// File: rtl/uart_baud_pkg.sv
// rtl/uart_baud_pkg.sv - shared defaults and helpers for the fractional baud generator
// Holds default widths, the after-reset divisor and the smallest legal integer divisor.
package uart_baud_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DEF_DIV_INT    = 325;
  localparam int DEF_DIV_FRAC   = 8;
  localparam int MIN_DIV        = 2;

  // Width of the oversample counter; keeps at least one bit when OVERSAMPLE is 1.
  function automatic int os_cnt_width(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// rtl/uart_baud_gen_frac_if.sv - divisor reload handshake between host and baud generator
// Signals:
//   cfg_valid  host offers a new divisor
//   cfg_ready  generator can accept a divisor
//   cfg_int    new integer divisor (legal >= 2)
//   cfg_frac   new fractional divisor
//   cfg_err    1-cycle pulse: offered cfg_int was below 2 and was rejected
interface uart_baud_gen_frac_if #(
  parameter int CNT_W  = uart_baud_pkg::CNT_W_DEF,
  parameter int FRAC_W = uart_baud_pkg::FRAC_W_DEF
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_err;

  modport master (output cfg_valid, cfg_int, cfg_frac, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_int, cfg_frac, output cfg_ready, cfg_err);

endinterface

// File: rtl/uart_frac_div.sv
// rtl/uart_frac_div.sv - fractional clock divider: cycle counter, phase accumulator, period
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   en_i             count enable; when low everything holds
//   restart_i        restart the interval from zero with period restart_int_i, acc cleared
//   restart_int_i    integer period used on restart
//   div_int_i        active integer divisor
//   div_frac_i       active fractional divisor
//   wrap_o           combinational: this cycle ends an interval
module uart_frac_div
  import uart_baud_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int DEF_DIV_INT = uart_baud_pkg::DEF_DIV_INT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic [CNT_W-1:0]  restart_int_i,
  input  logic [CNT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              wrap_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]    period_q, period_d;
  logic [FRAC_W:0]   acc_sum;

  // Carry out of the accumulator stretches the next interval by one clock.
  // period is one bit wider so div_int = 2^CNT_W-1 plus carry still fits.
  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac_i};
  assign wrap_o  = en_i && ({1'b0, cnt_q} == (period_q - (CNT_W+1)'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    period_d = period_q;
    if (restart_i) begin
      cnt_d    = '0;
      acc_d    = '0;
      period_d = {1'b0, restart_int_i};
    end else if (wrap_o) begin
      cnt_d    = '0;
      acc_d    = acc_sum[FRAC_W-1:0];
      period_d = {1'b0, div_int_i} + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      period_q <= (CNT_W+1)'(DEF_DIV_INT);
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - runtime-programmable fractional baud generator (os_tick, baud_tick)
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   en_i             1 = run, 0 = freeze counters and suppress ticks
//   resync_i         1-cycle pulse: restart oversample and baud phase
//   cfg              divisor reload handshake (slave side)
//   os_tick_o        registered pulse per oversample period
//   baud_tick_o      registered pulse per baud period, coincident with an os_tick
module uart_baud_gen_frac
  import uart_baud_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int DEF_DIV_INT  = uart_baud_pkg::DEF_DIV_INT,
  parameter int DEF_DIV_FRAC = uart_baud_pkg::DEF_DIV_FRAC
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 resync_i,
  uart_baud_gen_frac_if.slave  cfg,
  output logic                 os_tick_o,
  output logic                 baud_tick_o
);

  localparam int              OS_W    = os_cnt_width(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0]  div_int_q, div_int_d, pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d, pend_frac_q, pend_frac_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              os_tick_q, os_tick_d, baud_tick_q, baud_tick_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              wrap, tick, accept, apply;

  // A pending divisor lands on an interval boundary; with the divider frozen
  // or being resynced there is no interval in flight, so it lands at once.
  assign accept = cfg.cfg_valid && !pend_q;
  assign apply  = pend_q && (wrap || !en_i || resync_i);
  assign tick   = wrap && !resync_i;

  uart_frac_div #(
    .CNT_W       (CNT_W),
    .FRAC_W      (FRAC_W),
    .DEF_DIV_INT (DEF_DIV_INT)
  ) u_div (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .restart_i     (resync_i || apply),
    .restart_int_i (apply ? pend_int_q : div_int_q),
    .div_int_i     (div_int_q),
    .div_frac_i    (div_frac_q),
    .wrap_o        (wrap)
  );

  always_comb begin
    div_int_d   = div_int_q;
    div_frac_d  = div_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    err_d       = 1'b0;
    os_tick_d   = tick;
    baud_tick_d = tick && (os_cnt_q == OS_LAST);
    os_cnt_d    = os_cnt_q;

    if (resync_i) begin
      os_cnt_d = '0;
    end else if (tick) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
    end

    if (apply) begin
      div_int_d  = pend_int_q;
      div_frac_d = pend_frac_q;
      pend_d     = 1'b0;
    end

    // accept and apply never coincide: accept needs the pending slot empty.
    if (accept) begin
      if (cfg.cfg_int < CNT_W'(MIN_DIV)) begin
        err_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_int_d  = cfg.cfg_int;
        pend_frac_d = cfg.cfg_frac;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_int_q   <= CNT_W'(DEF_DIV_INT);
      div_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      os_cnt_q    <= '0;
    end else begin
      div_int_q   <= div_int_d;
      div_frac_q  <= div_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      os_cnt_q    <= os_cnt_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_err   = err_q;
  assign os_tick_o     = os_tick_q;
  assign baud_tick_o   = baud_tick_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - self-checking bench for uart_baud_gen_frac
module tb_uart_baud_gen_frac;

  localparam int CW = 16;
  localparam int FW = 4;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic resync = 1'b0;
  logic os_tick, baud_tick;

  uart_baud_gen_frac_if #(.CNT_W(CW), .FRAC_W(FW)) cfg_bus ();

  uart_baud_gen_frac #(
    .CNT_W(CW), .FRAC_W(FW), .OVERSAMPLE(OS), .DEF_DIV_INT(4), .DEF_DIV_FRAC(0)
  ) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .resync_i(resync),
    .cfg(cfg_bus), .os_tick_o(os_tick), .baud_tick_o(baud_tick)
  );

  always #5 clk = ~clk;

  typedef struct { int n; int total; } sb_t;
  typedef struct packed {
    logic [15:0]     dint;
    logic [3:0]      dfrac;
    logic [5:0][7:0] gaps;   // listed g1..g6, g1 in [5]
    logic [15:0]     sum16;  // total of gaps 7..22
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[6];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, last_tick = 0, os_seen = 0, sb_n = 0, sb_cyc = 0;
  bit   mark = 1'b0, mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Monitor: interval scoreboard plus baud phase relative to last reset/resync.
  always @(negedge clk) begin
    cyc++;
    if (mark) begin
      last_tick = cyc;
      mark = 1'b0;
    end
    if (mon_on) begin
      if (baud_tick) chk("baud_with_os", os_tick, 1);
      if (os_tick) begin
        os_seen++;
        chk("baud_phase", baud_tick, (os_seen % OS) == 0);
        if (exp_q.size() > 0) begin
          sb_n++;
          sb_cyc += cyc - last_tick;
          if (sb_n == exp_q[0].n) begin
            chk($sformatf("interval_x%0d", exp_q[0].n), sb_cyc, exp_q[0].total);
            void'(exp_q.pop_front());
            sb_n = 0;
            sb_cyc = 0;
          end
        end
        last_tick = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_after_tick();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (os_tick) got = 1'b1;
    end
    chk("tick_seen", got, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sb_empty(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
    chk("sb_drained", exp_q.size() == 0, 1);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      sb_n = 0;
      sb_cyc = 0;
    end
  endtask

  task automatic push_n(input int count, input int gap);
    for (int i = 0; i < count; i++) exp_q.push_back('{n: 1, total: gap});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_ready, got_tick;
    vecs[0] = '{dint: 16'd4, dfrac: 4'd0,  gaps: {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4}, sum16: 16'd64};
    vecs[1] = '{dint: 16'd4, dfrac: 4'd8,  gaps: {8'd4, 8'd4, 8'd5, 8'd4, 8'd5, 8'd4}, sum16: 16'd72};
    vecs[2] = '{dint: 16'd6, dfrac: 4'd0,  gaps: {8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6}, sum16: 16'd96};
    vecs[3] = '{dint: 16'd3, dfrac: 4'd15, gaps: {8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4}, sum16: 16'd63};
    vecs[4] = '{dint: 16'd2, dfrac: 4'd1,  gaps: {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, sum16: 16'd33};
    vecs[5] = '{dint: 16'd4, dfrac: 4'd0,  gaps: {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4}, sum16: 16'd64};

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_int   = '0;
    cfg_bus.cfg_frac  = '0;

    // Reset state
    step();
    step();
    chk("rst_os_tick", os_tick, 0);
    chk("rst_baud_tick", baud_tick, 0);
    chk("rst_cfg_err", cfg_bus.cfg_err, 0);
    chk("rst_cfg_ready", cfg_bus.cfg_ready, 1);
    reset = 1'b0;
    mark = 1'b1;
    os_seen = 0;
    mon_on = 1'b1;
    exp_q.push_back('{n: 1, total: 4});
    exp_q.push_back('{n: 3, total: 12});
    wait_sb_empty(100);

    // Table: reload divisor mid-interval, then check the interval sequence
    for (int v = 0; v < 6; v++) begin
      sync_after_tick();
      step();
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_int   = vecs[v].dint;
      cfg_bus.cfg_frac  = vecs[v].dfrac;
      step();
      cfg_bus.cfg_valid = 1'b0;
      chk($sformatf("vec%0d_ready_low", v), cfg_bus.cfg_ready, 0);
      got_ready = 1'b0;
      for (int i = 0; i < 40 && !got_ready; i++) begin
        step();
        if (cfg_bus.cfg_ready) begin
          got_ready = 1'b1;
          chk($sformatf("vec%0d_apply_on_tick", v), os_tick, 1);
        end
      end
      chk($sformatf("vec%0d_ready_back", v), got_ready, 1);
      @(negedge clk);
      #1;
      for (int i = 0; i < 6; i++) push_n(1, int'(vecs[v].gaps[5-i]));
      exp_q.push_back('{n: 16, total: int'(vecs[v].sum16)});
      wait_sb_empty(400);
    end

    // Illegal divisor: error pulse, nothing captured, spacing unchanged
    sync_after_tick();
    push_n(3, 4);
    step();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_int   = 16'd1;
    cfg_bus.cfg_frac  = 4'd3;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("err_pulse", cfg_bus.cfg_err, 1);
    chk("err_ready", cfg_bus.cfg_ready, 1);
    step();
    chk("err_drop", cfg_bus.cfg_err, 0);
    wait_sb_empty(100);

    // Resync on the wrap cycle: no tick, fresh interval and baud phase
    sync_after_tick();
    step();
    step();
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("resync_no_tick", os_tick, 0);
    mark = 1'b1;
    os_seen = 0;
    push_n(4, 4);
    wait_sb_empty(100);

    // en low for 10 clocks mid-interval
    sync_after_tick();
    push_n(1, 14);
    step();
    en = 1'b0;
    got_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (os_tick || baud_tick) got_tick = 1'b1;
    end
    en = 1'b1;
    chk("en_low_no_tick", got_tick, 0);
    wait_sb_empty(100);

    // Reset with a divisor pending: defaults come back, pending dropped
    sync_after_tick();
    step();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_int   = 16'd7;
    cfg_bus.cfg_frac  = 4'd0;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("pend_ready_low", cfg_bus.cfg_ready, 0);
    reset = 1'b1;
    step();
    chk("rst2_os_tick", os_tick, 0);
    chk("rst2_cfg_ready", cfg_bus.cfg_ready, 1);
    chk("rst2_cfg_err", cfg_bus.cfg_err, 0);
    reset = 1'b0;
    mark = 1'b1;
    os_seen = 0;
    push_n(4, 4);
    wait_sb_empty(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
